// File: rtl/pu_pkg.sv
// rtl/pu_pkg.sv - shared state encoding and arithmetic helpers for the pu_array MAC grid
package pu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } pu_state_t;

  // Wide enough that any lane sum is exact before range checking.
  localparam int ACC_W = 64;

  typedef struct packed {
    logic             ovf;
    logic [ACC_W-1:0] val;
  } sat_res_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Exact add, then range check against a w-bit signed result; clamps when sat is set.
  function automatic sat_res_t sat_add(input logic signed [ACC_W-1:0] a,
                                       input logic signed [ACC_W-1:0] b,
                                       input int                      w,
                                       input logic                    sat);
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    sat_res_t                r;
    sum   = a + b;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    r.ovf = (sum > hi) || (sum < lo);
    if (sat && (sum > hi))      r.val = hi;
    else if (sat && (sum < lo)) r.val = lo;
    else                        r.val = sum;
    return r;
  endfunction

endpackage

// File: rtl/pu_mac_lane.sv
// rtl/pu_mac_lane.sv - one signed multiply-accumulate lane with clear, enable and overflow flag
module pu_mac_lane
  import pu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int SATURATE     = 0
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [DATA_WIDTH-1:0]   x_i,
  input  logic [WEIGHT_WIDTH-1:0] w_i,
  output logic [OUTPUT_WIDTH-1:0] acc_o,
  output logic                    ovf_o
);

  logic signed [OUTPUT_WIDTH-1:0] acc_q;
  logic signed [OUTPUT_WIDTH-1:0] x_ext;
  logic signed [OUTPUT_WIDTH-1:0] w_ext;
  logic signed [OUTPUT_WIDTH-1:0] prod;
  sat_res_t                       sum;

  // Operands are sign-extended first so the product is exact at accumulator width.
  assign x_ext = OUTPUT_WIDTH'($signed(x_i));
  assign w_ext = OUTPUT_WIDTH'($signed(w_i));
  assign prod  = x_ext * w_ext;
  assign sum   = sat_add(ACC_W'(acc_q), ACC_W'(prod), OUTPUT_WIDTH, SATURATE != 0);
  assign acc_o = acc_q;
  assign ovf_o = en_i && sum.ovf;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= OUTPUT_WIDTH'(sum.val);
    end
  end

endmodule

// File: rtl/pu_array.sv
// rtl/pu_array.sv - MAC_NUM x COL_NUM signed MAC grid with job FSM and one-deep result buffer
module pu_array
  import pu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int OUTPUT_WIDTH = 32,
  parameter int MAC_NUM      = 8,
  parameter int COL_NUM      = 2,
  parameter int K_MAX        = 256,
  parameter int SATURATE     = 0,
  parameter int KW           = clog2(K_MAX + 1)
) (
  input  logic                                    clk_i,
  input  logic                                    rstn_i,
  input  logic                                    en_i,
  input  logic                                    abort_i,
  input  logic                                    start_i,
  input  logic [KW-1:0]                           k_len_i,
  input  logic                                    din_valid_i,
  output logic                                    din_ready_o,
  input  logic [DATA_WIDTH*MAC_NUM-1:0]           din_i,
  input  logic [WEIGHT_WIDTH*COL_NUM-1:0]         win_i,
  output logic                                    dout_valid_o,
  input  logic                                    dout_ready_i,
  output logic [OUTPUT_WIDTH*MAC_NUM*COL_NUM-1:0] dout_o,
  output logic                                    busy_o,
  output logic                                    overflow_o
);

  localparam int LANES = MAC_NUM * COL_NUM;

  pu_state_t                     state_q;
  logic [KW-1:0]                 cnt_q;
  logic [KW-1:0]                 k_len_q;
  logic [OUTPUT_WIDTH*LANES-1:0] acc_flat;
  logic [OUTPUT_WIDTH*LANES-1:0] dout_q;
  logic [LANES-1:0]              lane_ovf;
  logic                          dout_valid_q;
  logic                          overflow_q;
  logic                          beat;
  logic                          acc_en;
  logic                          acc_clr;
  logic                          start_ok;
  logic                          last_beat;
  logic                          load;

  assign din_ready_o  = (state_q == ACC) && en_i;
  assign beat         = din_valid_i && din_ready_o;
  assign acc_en       = beat && !abort_i;
  assign start_ok     = (state_q == IDLE) && start_i && (k_len_i != '0) && en_i && !abort_i;
  assign acc_clr      = abort_i || start_ok;
  assign last_beat    = acc_en && (cnt_q == k_len_q - KW'(1));
  // The buffer copy ignores en_i so a stalled pipe can still hand off its result.
  assign load         = (state_q == DONE) && !abort_i && (!dout_valid_q || dout_ready_i);

  assign dout_valid_o = dout_valid_q;
  assign dout_o       = dout_q;
  assign busy_o       = (state_q != IDLE);
  assign overflow_o   = overflow_q;

  for (genvar c = 0; c < COL_NUM; c++) begin : g_col
    for (genvar r = 0; r < MAC_NUM; r++) begin : g_row
      pu_mac_lane #(
        .DATA_WIDTH  (DATA_WIDTH),
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .OUTPUT_WIDTH(OUTPUT_WIDTH),
        .SATURATE    (SATURATE)
      ) u_lane (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .clr_i (acc_clr),
        .en_i  (acc_en),
        .x_i   (din_i[r*DATA_WIDTH +: DATA_WIDTH]),
        .w_i   (win_i[c*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
        .acc_o (acc_flat[(c*MAC_NUM+r)*OUTPUT_WIDTH +: OUTPUT_WIDTH]),
        .ovf_o (lane_ovf[c*MAC_NUM+r])
      );
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      k_len_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      // A drain and a refill in the same cycle leave the buffer full with the new result.
      if (load) begin
        dout_q       <= acc_flat;
        dout_valid_q <= 1'b1;
      end else if (dout_valid_q && dout_ready_i) begin
        dout_valid_q <= 1'b0;
      end

      if (start_ok) begin
        overflow_q <= 1'b0;
      end else if (|lane_ovf) begin
        overflow_q <= 1'b1;
      end

      if (abort_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_ok) begin
              state_q <= ACC;
              k_len_q <= k_len_i;
              cnt_q   <= '0;
            end
          end
          ACC: begin
            if (acc_en) begin
              cnt_q <= cnt_q + KW'(1);
              if (last_beat) state_q <= DONE;
            end
          end
          DONE: begin
            if (load) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pu_array.sv
// tb/tb_pu_array.sv - directed self-checking bench for pu_array in wrap and saturate configurations
module tb_pu_array;

  localparam int DW = 8;
  localparam int WW = 8;
  localparam int MN = 8;
  localparam int CN = 2;
  localparam int KW = 9;

  logic              clk = 1'b0;
  logic              rstn;
  logic              en;
  logic              abort;
  logic              start;
  logic [KW-1:0]     k_len;
  logic              din_valid;
  logic [DW*MN-1:0]  din;
  logic [WW*CN-1:0]  win;
  logic              dout_ready;

  logic              din_ready_m, dout_valid_m, busy_m, overflow_m;
  logic [32*MN*CN-1:0] dout_m;
  logic              din_ready_s, dout_valid_s, busy_s, overflow_s;
  logic [16*MN*CN-1:0] dout_s;
  logic              din_ready_w, dout_valid_w, busy_w, overflow_w;
  logic [16*MN*CN-1:0] dout_w;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  pu_array u_main (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .abort_i(abort), .start_i(start), .k_len_i(k_len),
    .din_valid_i(din_valid), .din_ready_o(din_ready_m), .din_i(din), .win_i(win),
    .dout_valid_o(dout_valid_m), .dout_ready_i(dout_ready), .dout_o(dout_m),
    .busy_o(busy_m), .overflow_o(overflow_m)
  );

  pu_array #(.OUTPUT_WIDTH(16), .SATURATE(1)) u_sat (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .abort_i(abort), .start_i(start), .k_len_i(k_len),
    .din_valid_i(din_valid), .din_ready_o(din_ready_s), .din_i(din), .win_i(win),
    .dout_valid_o(dout_valid_s), .dout_ready_i(dout_ready), .dout_o(dout_s),
    .busy_o(busy_s), .overflow_o(overflow_s)
  );

  pu_array #(.OUTPUT_WIDTH(16), .SATURATE(0)) u_wrap (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .abort_i(abort), .start_i(start), .k_len_i(k_len),
    .din_valid_i(din_valid), .din_ready_o(din_ready_w), .din_i(din), .win_i(win),
    .dout_valid_o(dout_valid_w), .dout_ready_i(dout_ready), .dout_o(dout_w),
    .busy_o(busy_w), .overflow_o(overflow_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_w(input int w0, input int w1);
    win = {8'(w1), 8'(w0)};
  endtask

  task automatic set_din(input int base, input bit ramp);
    for (int r = 0; r < MN; r++) din[r*DW +: DW] = 8'(ramp ? base * (r + 1) : base);
  endtask

  task automatic start_job(input int k);
    start = 1'b1;
    k_len = KW'(k);
    tick();
    start = 1'b0;
  endtask

  // Lanes carry x = r+1, so every result is a per-column weight sum scaled by (r+1).
  task automatic chk_res(input string tag, input int s0, input int s1);
    for (int r = 0; r < MN; r++) begin
      chk($sformatf("%s_c0_r%0d", tag, r), dout_m[r*32 +: 32], 32'(s0 * (r + 1)));
      chk($sformatf("%s_c1_r%0d", tag, r), dout_m[(MN+r)*32 +: 32], 32'(s1 * (r + 1)));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t2_en [10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
    int t2_v  [10] = '{1, 0, 1, 1, 1, 1, 1, 0, 1, 1};
    int t2_w0 [10] = '{1, 100, 2, 50, 50, 50, 3, 0, 4, 5};
    int t2_w1 [10] = '{-1, 100, -2, 50, 50, 50, -3, 0, 4, 0};

    rstn = 1'b0; en = 1'b0; abort = 1'b0; start = 1'b0; k_len = '0;
    din_valid = 1'b0; din = '0; win = '0; dout_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(dout_valid_m), 32'd0);
    chk("rst_busy", 32'(busy_m), 32'd0);
    chk("rst_ready", 32'(din_ready_m), 32'd0);
    chk("rst_ovf", 32'(overflow_m), 32'd0);
    chk("rst_dout", dout_m[31:0], 32'd0);
    rstn = 1'b1;
    tick();

    // T1: k_len=4, weights 2 / -3
    en = 1'b1;
    set_din(1, 1);
    start_job(4);
    chk("t1_busy", 32'(busy_m), 32'd1);
    chk("t1_din_ready", 32'(din_ready_m), 32'd1);
    din_valid = 1'b1;
    set_w(2, -3);
    repeat (4) tick();
    din_valid = 1'b0;
    chk("t1_done_busy", 32'(busy_m), 32'd1);
    chk("t1_done_ready", 32'(din_ready_m), 32'd0);
    chk("t1_valid_early", 32'(dout_valid_m), 32'd0);
    tick();
    chk("t1_valid", 32'(dout_valid_m), 32'd1);
    chk("t1_idle", 32'(busy_m), 32'd0);
    chk_res("t1", 8, -12);

    // T2: valid gaps and an en_i stall, k_len=5
    dout_ready = 1'b1;
    tick();
    chk("t2_drained", 32'(dout_valid_m), 32'd0);
    start_job(5);
    for (int i = 0; i < 10; i++) begin
      en = t2_en[i][0];
      din_valid = t2_v[i][0];
      set_w(t2_w0[i], t2_w1[i]);
      if (i == 3) begin
        #1;
        chk("t2_stall_ready", 32'(din_ready_m), 32'd0);
      end
      tick();
    end
    en = 1'b1;
    din_valid = 1'b0;
    tick();
    dout_ready = 1'b0;
    chk("t2_valid", 32'(dout_valid_m), 32'd1);
    chk_res("t2", 15, -2);

    // T3: second job completes into a full buffer
    start_job(2);
    din_valid = 1'b1;
    set_w(7, 1);
    repeat (2) tick();
    din_valid = 1'b0;
    repeat (2) tick();
    chk("t3_hold_busy", 32'(busy_m), 32'd1);
    chk("t3_hold_ready", 32'(din_ready_m), 32'd0);
    chk("t3_hold_valid", 32'(dout_valid_m), 32'd1);
    chk("t3_hold_c0r0", dout_m[31:0], 32'd15);
    chk("t3_hold_c1r7", dout_m[15*32 +: 32], 32'(-16));
    dout_ready = 1'b1;
    tick();
    chk("t3_refill_valid", 32'(dout_valid_m), 32'd1);
    chk("t3_refill_idle", 32'(busy_m), 32'd0);
    chk_res("t3", 14, 2);
    tick();
    chk("t3_drained", 32'(dout_valid_m), 32'd0);
    dout_ready = 1'b0;

    // T4: 3 x 127*127 against 16-bit saturate and wrap variants
    set_din(127, 0);
    set_w(127, 127);
    start_job(3);
    din_valid = 1'b1;
    repeat (3) tick();
    din_valid = 1'b0;
    tick();
    chk("t4_main_lane0", dout_m[31:0], 32'd48387);
    chk("t4_main_ovf", 32'(overflow_m), 32'd0);
    chk("t4_sat_lane0", 32'(dout_s[15:0]), 32'd32767);
    chk("t4_sat_lane15", 32'(dout_s[15*16 +: 16]), 32'd32767);
    chk("t4_sat_ovf", 32'(overflow_s), 32'd1);
    chk("t4_wrap_lane0", 32'(dout_w[15:0]), 32'h0000_BD03);
    chk("t4_wrap_ovf", 32'(overflow_w), 32'd1);

    // T5: overflow clear on start, abort mid-job, k_len=1, ignored starts
    set_din(1, 1);
    set_w(1, 1);
    start_job(8);
    chk("t5_sat_ovf_clr", 32'(overflow_s), 32'd0);
    chk("t5_wrap_ovf_clr", 32'(overflow_w), 32'd0);
    din_valid = 1'b1;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    din_valid = 1'b0;
    chk("t5_abort_idle", 32'(busy_m), 32'd0);
    chk("t5_abort_valid", 32'(dout_valid_m), 32'd1);
    chk("t5_abort_dout", dout_m[31:0], 32'd48387);
    dout_ready = 1'b1;
    tick();
    chk("t5_drained", 32'(dout_valid_m), 32'd0);
    start_job(1);
    din_valid = 1'b1;
    set_w(5, -7);
    tick();
    din_valid = 1'b0;
    tick();
    chk("t5_k1_valid", 32'(dout_valid_m), 32'd1);
    chk_res("t5_k1", 5, -7);
    dout_ready = 1'b0;
    start_job(0);
    chk("t5_k0_idle", 32'(busy_m), 32'd0);
    abort = 1'b1;
    start_job(3);
    abort = 1'b0;
    chk("t5_abort_start_idle", 32'(busy_m), 32'd0);

    // T6: asynchronous reset mid-job with a full buffer
    start_job(4);
    din_valid = 1'b1;
    tick();
    rstn = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(dout_valid_m), 32'd0);
    chk("t6_rst_busy", 32'(busy_m), 32'd0);
    chk("t6_rst_ready", 32'(din_ready_m), 32'd0);
    chk("t6_rst_ovf", 32'(overflow_m), 32'd0);
    chk("t6_rst_dout", dout_m[31:0], 32'd0);
    chk("t6_rst_sat_valid", 32'(dout_valid_s), 32'd0);
    din_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    start_job(2);
    din_valid = 1'b1;
    set_w(1, 1);
    tick();
    set_w(2, -1);
    tick();
    din_valid = 1'b0;
    tick();
    chk("t6_valid", 32'(dout_valid_m), 32'd1);
    chk_res("t6", 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
